rf_write_arbiter: RTL and testbench



---
 rtl/rf_write_arbiter.sv | 81 ++++++++
 tb/tb_rf_write_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Round-robin arbiter that shares the single write port of the register
//   file among NREQ requesters. A grant is decided combinationally in the
//   same cycle. The accepted write is registered onto wr_* one cycle later.
//
// Ports
//   clk, reset   clock and synchronous active-high reset
//   req_valid    per-requester pending-write flags
//   req_addr     requester i address in [i*AW +: AW]
//   req_data     requester i data in [i*DW +: DW]
//   req_ready    one-hot grant; a transfer happens when valid & ready
//   rf_stall     register file cannot accept a write this cycle
//   wr_en        registered write strobe
//   wr_addr      registered write address, to the 3-to-8 decoder
//   wr_data      registered write data
//   wr_src       index of the requester whose write is on the port
module rf_write_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int AW   = 3,
  parameter int SW   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 rf_stall,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        wr_data,
  output logic [SW-1:0]        wr_src
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] gnt;
  logic          gnt_vld;
  int            idx;

  // Search req_valid starting at ptr and wrapping modulo NREQ; the first set
  // bit wins. Reset and stall block every grant, so nothing is accepted then.
  always_comb begin
    req_ready = '0;
    gnt       = '0;
    gnt_vld   = 1'b0;
    idx       = 0;
    if (!reset && !rf_stall) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!gnt_vld && req_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt     = SW'(idx);
        end
      end
    end
    req_ready[gnt] = gnt_vld;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_src  <= '0;
    end else if (gnt_vld) begin
      wr_en   <= 1'b1;
      wr_addr <= req_addr[gnt*AW +: AW];
      wr_data <= req_data[gnt*DW +: DW];
      wr_src  <= gnt;
      // Pointer moves just past the winner; explicit wrap since NREQ need
      // not be a power of two.
      ptr     <= (gnt == SW'(NREQ-1)) ? '0 : gnt + SW'(1);
    end else begin
      // Address/data/source hold; only the strobe drops.
      wr_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
//   Self-checking bench for rf_write_arbiter (NREQ=4, DW=32, AW=3, SW=2).
//   A behavioural model (round-robin search over the valid set, plus an
//   8-entry register file array) runs alongside every cycle; table rows and
//   hand-written sequences add fixed expectations on top.
module tb_rf_write_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int AW   = 3;
  localparam int SW   = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                rf_stall;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;
  logic [SW-1:0]       wr_src;

  rf_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .SW(SW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .rf_stall(rf_stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_src(wr_src)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state
  int              m_ptr;
  logic            m_en;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;
  int              m_src;
  logic [DW-1:0]   m_rf [8];
  logic [NREQ-1:0] exp_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Grant = first valid requester at cyclic distance 0,1,.. from the pointer.
  function automatic int model_grant();
    if (reset || rf_stall) return -1;
    for (int d = 0; d < NREQ; d++)
      if (req_valid[(m_ptr + d) % NREQ]) return (m_ptr + d) % NREQ;
    return -1;
  endfunction

  task automatic model_edge();
    int g;
    g = model_grant();
    if (m_en) m_rf[m_addr] = m_data;
    if (reset) begin
      m_ptr = 0; m_en = 0; m_addr = '0; m_data = '0; m_src = 0;
    end else if (g >= 0) begin
      m_en = 1; m_addr = req_addr[g*AW +: AW]; m_data = req_data[g*DW +: DW];
      m_src = g; m_ptr = (g + 1) % NREQ;
    end else begin
      m_en = 0;
    end
  endtask

  // One clock: inputs were driven after the falling edge; check the grant
  // before the rising edge and the registered outputs just after it.
  task automatic cycle(input string tag);
    int g;
    #1;
    g = model_grant();
    exp_ready = (g >= 0) ? NREQ'(1 << g) : '0;
    chk({tag, " ready"}, 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, " wr_en"}, 32'(wr_en), 32'(m_en));
    chk({tag, " wr_addr"}, 32'(wr_addr), 32'(m_addr));
    chk({tag, " wr_data"}, wr_data, m_data);
    chk({tag, " wr_src"}, 32'(wr_src), 32'(m_src));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; req_valid = '0; rf_stall = 0;
    cycle("rst");
    reset = 0;
  endtask

  task automatic set_lanes_idx();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = AW'(i);
      req_data[i*DW +: DW] = 32'h100 + 32'(i);
    end
  endtask

  typedef struct {
    logic [NREQ-1:0] valid;
    logic            stall;
    logic [NREQ-1:0] ready;
    logic            en;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [SW-1:0]   src;
  } vec_t;

  vec_t tbl [8];

  initial begin
    reset = 1; req_valid = '0; req_addr = '0; req_data = '0; rf_stall = 0;
    m_ptr = 0; m_en = 0; m_addr = '0; m_data = '0; m_src = 0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    @(negedge clk);

    // ---- reset with every requester valid
    req_valid = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      cycle("reset");
      chk("reset ready0", 32'(exp_ready), 32'h0);
      chk("reset wr_en0", 32'(wr_en), 32'h0);
      chk("reset wr_data0", wr_data, 32'h0);
    end
    reset = 0;
    set_lanes_idx();
    cycle("post_reset");
    chk("post_reset grant0", 32'(exp_ready), 32'b0001);

    // ---- table-driven vectors from a fresh reset (ptr=0)
    do_reset();
    tbl[0] = '{4'b0100, 0, 4'b0100, 1, 3'd5, 32'hDEADBEEF, 2'd2};
    tbl[1] = '{4'b0000, 0, 4'b0000, 0, 3'd5, 32'hDEADBEEF, 2'd2};
    tbl[2] = '{4'b1111, 0, 4'b1000, 1, 3'd3, 32'h103, 2'd3};
    tbl[3] = '{4'b1111, 0, 4'b0001, 1, 3'd0, 32'h100, 2'd0};
    tbl[4] = '{4'b1111, 1, 4'b0000, 0, 3'd0, 32'h100, 2'd0};
    tbl[5] = '{4'b1010, 0, 4'b0010, 1, 3'd1, 32'h101, 2'd1};
    tbl[6] = '{4'b1010, 0, 4'b1000, 1, 3'd3, 32'h103, 2'd3};
    tbl[7] = '{4'b0001, 0, 4'b0001, 1, 3'd0, 32'h100, 2'd0};
    for (int r = 0; r < 8; r++) begin
      if (r < 2) begin
        req_addr = '0; req_data = '0;
        req_addr[2*AW +: AW] = 3'd5;
        req_data[2*DW +: DW] = 32'hDEADBEEF;
      end else set_lanes_idx();
      req_valid = tbl[r].valid; rf_stall = tbl[r].stall;
      cycle($sformatf("tbl%0d", r));
      chk($sformatf("tbl%0d ready", r), 32'(exp_ready), 32'(tbl[r].ready));
      chk($sformatf("tbl%0d en", r), 32'(wr_en), 32'(tbl[r].en));
      chk($sformatf("tbl%0d addr", r), 32'(wr_addr), 32'(tbl[r].addr));
      chk($sformatf("tbl%0d data", r), wr_data, tbl[r].data);
      chk($sformatf("tbl%0d src", r), 32'(wr_src), 32'(tbl[r].src));
    end

    // ---- round robin, all valid for 8 cycles
    do_reset();
    set_lanes_idx();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      cycle("rr");
      chk("rr order", 32'(exp_ready), 32'(1 << (k % 4)));
      chk("rr continuous", 32'(wr_en), 32'h1);
      chk("rr src", 32'(wr_src), 32'(k % 4));
    end

    // ---- stall for 3 cycles with 1 and 3 valid
    do_reset();
    req_valid = 4'b1010; rf_stall = 1;
    for (int k = 0; k < 3; k++) begin
      cycle("stall");
      chk("stall ready", 32'(exp_ready), 32'h0);
      chk("stall wr_en", 32'(wr_en), 32'h0);
    end
    rf_stall = 0;
    cycle("stall_rel1");
    chk("stall_rel grant1", 32'(wr_src), 32'd1);
    req_valid = 4'b1000;
    cycle("stall_rel2");
    chk("stall_rel grant3", 32'(wr_src), 32'd3);
    req_valid = '0;

    // ---- same-address contention
    do_reset();
    req_addr = '0; req_data = '0;
    req_addr[0 +: AW] = 3'd7; req_data[0 +: DW] = 32'h11;
    req_addr[AW +: AW] = 3'd7; req_data[DW +: DW] = 32'h22;
    req_valid = 4'b0011;
    cycle("same1");
    chk("same first data", wr_data, 32'h11);
    req_valid = 4'b0010;
    cycle("same2");
    chk("same second data", wr_data, 32'h22);
    req_valid = '0;
    cycle("same3");
    chk("same rf7", m_rf[7], 32'h22);
    chk("same wr_en drop", 32'(wr_en), 32'h0);

    // ---- reset arriving at the accepting edge of a grant to requester 2
    do_reset();
    set_lanes_idx();
    req_valid = 4'b0011;
    cycle("mid_a");
    req_valid = 4'b0010;
    cycle("mid_b");
    req_valid = 4'b0100;
    #1;
    chk("mid grant2 seen", 32'(req_ready), 32'b0100);
    reset = 1;
    cycle("mid_rst");
    chk("mid wr_en", 32'(wr_en), 32'h0);
    chk("mid wr_data", wr_data, 32'h0);
    reset = 0;
    req_valid = 4'b0101;
    cycle("mid_after");
    chk("mid ptr0", 32'(wr_src), 32'd0);

    // ---- randomized traffic; requesters hold until granted, may withdraw
    begin
      logic [NREQ-1:0] pend;
      pend = '0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!pend[i]) begin
            if ($urandom_range(1, 0) == 1) begin
              pend[i] = 1;
              req_addr[i*AW +: AW] = AW'($urandom);
              req_data[i*DW +: DW] = $urandom;
            end
          end else if ($urandom_range(15, 0) == 0) pend[i] = 0;
        end
        req_valid = pend;
        rf_stall  = ($urandom_range(3, 0) == 0);
        reset     = ($urandom_range(59, 0) == 0);
        cycle("rand");
        pend = pend & ~exp_ready;
        reset = 0;
      end
      req_valid = '0;
      cycle("rand_end");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
